prog_sram_ctrl: RTL
===================

Name: prog_sram_ctrl

Overview:
- Consumes the byte-write stream from the serial program loader (adr/data/write) and performs timed write cycles on the external asynchronous 8-bit SRAM.
- Also serves single-byte reads from the console side (cpu_*) on the same SRAM.
- Sits between the loader/CPU bus and the SRAM pads.
- Provides a one-entry write holding register, read/write arbitration, a written-byte counter and a sticky overrun flag.

Parameters:
ADR_W, 21, address width of loader, CPU and SRAM address buses
WE_CYCLES, 2, clocks sram_we_n is held low per write (>=1)
RD_CYCLES, 2, clocks from address/OE valid to data sample (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
ld_adr  in  ADR_W  loader byte address, stable the cycle before and during ld_write
ld_data  in  8  loader byte, stable the cycle before and during ld_write
ld_write  in  1  one-cycle write strobe from loader
cpu_adr  in  ADR_W  read address, sampled on cpu_rd
cpu_rd  in  1  one-cycle read request
cpu_rdata  out  8  read data, valid when cpu_ack
cpu_ack  out  1  one-cycle read completion pulse
busy  out  1  controller not idle, or a write/read is pending
overrun  out  1  sticky: write strobe lost
wr_count  out  ADR_W  bytes committed to SRAM since reset
sram_adr  out  ADR_W  SRAM address
sram_dq_out  out  8  SRAM data out
sram_dq_oe  out  1  drive enable for sram_dq pads
sram_dq_in  in  8  SRAM data in (pad input)
sram_ce_n  out  1  chip enable, active low
sram_we_n  out  1  write enable, active low
sram_oe_n  out  1  output enable, active low

Behaviour:
Reset (reset_n low at clk edge):
- state=IDLE; pending write and read flags clear.
- cpu_ack=0, cpu_rdata=0, overrun=0, wr_count=0.
- sram_ce_n=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_adr=0, sram_dq_out=0.
- Reset mid-cycle aborts the cycle immediately; the aborted byte is not counted.

Capture:
- ld_write=1 captures {ld_adr, ld_data} into the write hold register and sets wpend.
- If wpend is already set, the strobe is dropped and overrun is set. The held byte is kept and overrun stays set until reset.
- cpu_rd=1 captures cpu_adr and sets rpend. cpu_rd while rpend is set is ignored; the CPU must wait for cpu_ack.
- Capture happens in the same cycle as any state activity. A strobe arriving in the cycle its register is freed is accepted.

State machine (one counter, cnt):
- IDLE:
  - wpend -> W_SETUP: drive sram_adr and sram_dq_out, dq_oe=1, ce_n=0. wpend clears when W_SETUP is entered.
  - else rpend -> R_WAIT: drive sram_adr, ce_n=0, oe_n=0, cnt=RD_CYCLES-1.
  - A write always has priority over a simultaneous read.
- W_SETUP (1 clk) -> W_PULSE: we_n=0, cnt=WE_CYCLES-1.
- W_PULSE: hold we_n=0 until cnt==0, decrementing each clk, then -> W_HOLD with we_n=1.
  - Address and data stay stable for the whole pulse.
- W_HOLD (1 clk): adr/data held, we_n=1, then -> IDLE.
  - On leaving W_HOLD: dq_oe=0, ce_n=1, wr_count+=1 (wraps modulo 2^ADR_W).
- R_WAIT: decrement cnt; at cnt==0 register sram_dq_in into cpu_rdata and pulse cpu_ack=1 for one clk.
  - Then oe_n=1, ce_n=1, rpend clears, -> IDLE.
  - cpu_rdata holds its value until the next read.

Invariants:
- sram_we_n and sram_oe_n are never both low.
- sram_dq_oe is never 1 while oe_n=0.
- One full IDLE cycle separates consecutive SRAM cycles (bus turnaround).

Timing and busy:
- Write latency with defaults: strobe -> IDLE sees wpend next clk -> we_n low 2 clks later. Total occupancy 1 setup + WE_CYCLES + 1 hold.
- busy = (state!=IDLE) | wpend | rpend. It is combinational from registered state.

Test Plan:
1. Reset, single write: ld_adr=0x00010, ld_data=0xA5, one-cycle strobe. Required: sram_adr=0x00010, dq_out=0xA5, dq_oe=1 through the cycle; we_n low exactly 2 clks, with address stable 1 clk before and 1 clk after; wr_count=1; busy returns to 0.
2. Back-to-back loader bytes at a 48-clk spacing, addresses 0..255 with data=adr^0x5A. Required: a model SRAM matches all 256 bytes, wr_count=256, overrun=0.
3. Overrun: two strobes 1 clk apart, a third 1 clk later. Required: the first and second bytes are written (second was captured after the hold freed), the third is dropped, overrun=1 and stays 1 until reset_n low.
4. Read: preload model SRAM[0x1FFFFF]=0x3C, pulse cpu_rd with cpu_adr=0x1FFFFF. Required: oe_n low RD_CYCLES clks, cpu_ack one clk pulse with cpu_rdata=0x3C; we_n stays 1 throughout.
5. Simultaneous ld_write and cpu_rd in an IDLE cycle. Required: the write cycle runs first, then an idle cycle, then the read; the read returns the newly written byte if the addresses match.
6. reset_n low during W_PULSE. Required: next clk we_n=1, ce_n=1, dq_oe=0, wr_count=0, overrun=0, state IDLE; no cpu_ack.

Source files
------------

// File: rtl/prog_sram_ctrl_if.sv
// Loader and console-read bus between the program loader / CPU side and prog_sram_ctrl.
interface prog_sram_ctrl_if #(
    parameter int ADR_W = 21
);
    logic [ADR_W-1:0] ld_adr;
    logic [7:0]       ld_data;
    logic             ld_write;
    logic [ADR_W-1:0] cpu_adr;
    logic             cpu_rd;
    logic [7:0]       cpu_rdata;
    logic             cpu_ack;

    modport master (
        output ld_adr, ld_data, ld_write, cpu_adr, cpu_rd,
        input  cpu_rdata, cpu_ack
    );

    modport slave (
        input  ld_adr, ld_data, ld_write, cpu_adr, cpu_rd,
        output cpu_rdata, cpu_ack
    );
endinterface

// File: rtl/prog_sram_ctrl.sv
// Timed write/read cycles on an external async 8-bit SRAM for the program loader and console reads.
// state   | meaning
// IDLE    | bus released; picks pending write first, then pending read
// W_SETUP | address/data/ce driven, we_n still high
// W_PULSE | we_n low for WE_CYCLES clocks
// W_HOLD  | we_n high, address/data held one more clock
// R_WAIT  | ce_n/oe_n low, sample data after RD_CYCLES clocks
module prog_sram_ctrl #(
    parameter int ADR_W     = 21,
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    prog_sram_ctrl_if.slave  bus,
    output logic             busy,
    output logic             overrun,
    output logic [ADR_W-1:0] wr_count,
    output logic [ADR_W-1:0] sram_adr,
    output logic [7:0]       sram_dq_out,
    output logic             sram_dq_oe,
    input  logic [7:0]       sram_dq_in,
    output logic             sram_ce_n,
    output logic             sram_we_n,
    output logic             sram_oe_n
);
    localparam int CNT_MAX = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wpend_q, wpend_d, rpend_q, rpend_d;
    logic [ADR_W-1:0] w_adr_q, w_adr_d, r_adr_q, r_adr_d;
    logic [7:0]       w_data_q, w_data_d;
    logic [7:0]       rdata_d;
    logic             ack_d, ovr_d;
    logic [ADR_W-1:0] wr_count_d, adr_d;
    logic [7:0]       dq_d;
    logic             dq_oe_d, ce_d, we_d, oe_d;
    logic             w_free, r_free;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wpend_d    = wpend_q;
        rpend_d    = rpend_q;
        w_adr_d    = w_adr_q;
        w_data_d   = w_data_q;
        r_adr_d    = r_adr_q;
        rdata_d    = bus.cpu_rdata;
        ack_d      = 1'b0;
        ovr_d      = overrun;
        wr_count_d = wr_count;
        adr_d      = sram_adr;
        dq_d       = sram_dq_out;
        dq_oe_d    = sram_dq_oe;
        ce_d       = sram_ce_n;
        we_d       = sram_we_n;
        oe_d       = sram_oe_n;
        w_free     = 1'b0;
        r_free     = 1'b0;

        case (state_q)
            IDLE: begin
                if (wpend_q) begin
                    state_d = W_SETUP;
                    adr_d   = w_adr_q;
                    dq_d    = w_data_q;
                    dq_oe_d = 1'b1;
                    ce_d    = 1'b0;
                    w_free  = 1'b1;
                end else if (rpend_q) begin
                    state_d = R_WAIT;
                    adr_d   = r_adr_q;
                    ce_d    = 1'b0;
                    oe_d    = 1'b0;
                    cnt_d   = CNT_W'(RD_CYCLES - 1);
                end
            end
            W_SETUP: begin
                state_d = W_PULSE;
                we_d    = 1'b0;
                cnt_d   = CNT_W'(WE_CYCLES - 1);
            end
            W_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = W_HOLD;
                    we_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            W_HOLD: begin
                state_d    = IDLE;
                dq_oe_d    = 1'b0;
                ce_d       = 1'b1;
                wr_count_d = wr_count + 1'b1;
            end
            R_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    rdata_d = sram_dq_in;
                    ack_d   = 1'b1;
                    oe_d    = 1'b1;
                    ce_d    = 1'b1;
                    r_free  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A strobe landing in the same cycle its holding register empties is taken.
        if (w_free) wpend_d = 1'b0;
        if (r_free) rpend_d = 1'b0;
        if (bus.ld_write) begin
            if (!wpend_q || w_free) begin
                wpend_d  = 1'b1;
                w_adr_d  = bus.ld_adr;
                w_data_d = bus.ld_data;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (bus.cpu_rd && (!rpend_q || r_free)) begin
            rpend_d = 1'b1;
            r_adr_d = bus.cpu_adr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wpend_q       <= 1'b0;
            rpend_q       <= 1'b0;
            w_adr_q       <= '0;
            w_data_q      <= '0;
            r_adr_q       <= '0;
            bus.cpu_rdata <= '0;
            bus.cpu_ack   <= 1'b0;
            overrun       <= 1'b0;
            wr_count      <= '0;
            sram_adr      <= '0;
            sram_dq_out   <= '0;
            sram_dq_oe    <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wpend_q       <= wpend_d;
            rpend_q       <= rpend_d;
            w_adr_q       <= w_adr_d;
            w_data_q      <= w_data_d;
            r_adr_q       <= r_adr_d;
            bus.cpu_rdata <= rdata_d;
            bus.cpu_ack   <= ack_d;
            overrun       <= ovr_d;
            wr_count      <= wr_count_d;
            sram_adr      <= adr_d;
            sram_dq_out   <= dq_d;
            sram_dq_oe    <= dq_oe_d;
            sram_ce_n     <= ce_d;
            sram_we_n     <= we_d;
            sram_oe_n     <= oe_d;
        end
    end

    assign busy = (state_q != IDLE) | wpend_q | rpend_q;
endmodule
